// File: rtl/trng_pkg.sv
// Shared types and defaults for the ring-oscillator TRNG controller.
// No logic; imported by trng_sync and trng_ctrl.
package trng_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int BYTE_W         = 8;
  localparam int DEF_N_RO       = 4;
  localparam int DEF_WARMUP     = 64;
  localparam int DEF_SAMPLE_DIV = 8;
endpackage

// File: rtl/trng_sync.sv
// N-wide two-flop synchroniser for the free-running oscillator outputs.
// Latency 2 clk; no backpressure, runs in every state.
module trng_sync
  import trng_pkg::*;
#(
  parameter int W = DEF_N_RO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: warm-up, divided XOR sampling, byte packing; byte held until data_ready.
// Optional von Neumann debiasing when TRNG_VON_NEUMANN_EN is defined; en=0 aborts to IDLE.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int N_RO          = DEF_N_RO,
  parameter int WARMUP_CYCLES = DEF_WARMUP,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              ro_en,
  input  logic [N_RO-1:0]   ro_bits,
  output logic [BYTE_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy
);
  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int BW = $clog2(BYTE_W);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BYTE_W - 1);

  logic [N_RO-1:0]   w_sync;
  logic              w_raw;
  logic              w_tick;
  logic              w_acc_vld;
  logic              w_acc_bit;

  state_t            r_state;
  logic              r_ro_en;
  logic              r_busy;
  logic              r_data_valid;
  logic [BYTE_W-1:0] r_data_out;
  logic [BYTE_W-1:0] r_shreg;
  logic [WW-1:0]     r_wcnt;
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bcnt;

  trng_sync #(.W(N_RO)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (ro_bits),
    .o_q   (w_sync)
  );

  assign w_raw  = ^w_sync;
  assign w_tick = (r_state == ST_SAMPLE) && (r_div == DIV_LAST);

`ifdef TRNG_VON_NEUMANN_EN
  logic r_vn_have;
  logic r_vn_first;

  // Pair register only lives inside SAMPLE, so leaving it (abort or HOLD) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (!en || r_state != ST_SAMPLE) begin
      r_vn_have  <= 1'b0;
      r_vn_first <= 1'b0;
    end else if (w_tick) begin
      r_vn_have  <= !r_vn_have;
      r_vn_first <= r_vn_have ? r_vn_first : w_raw;
    end
  end

  assign w_acc_vld = w_tick && r_vn_have && (r_vn_first != w_raw);
  assign w_acc_bit = r_vn_first;
`else
  assign w_acc_vld = w_tick;
  assign w_acc_bit = w_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ro_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
      r_shreg      <= '0;
      r_wcnt       <= '0;
      r_div        <= '0;
      r_bcnt       <= '0;
    end else if (r_state != ST_IDLE && !en) begin
      r_state      <= ST_IDLE;
      r_ro_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_data_valid <= 1'b0;
      r_shreg      <= '0;
      r_wcnt       <= '0;
      r_div        <= '0;
      r_bcnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_WARMUP;
            r_ro_en <= 1'b1;
            r_busy  <= 1'b1;
            r_wcnt  <= '0;
          end
        end
        ST_WARMUP: begin
          if (r_wcnt == WARM_LAST) begin
            r_state <= ST_SAMPLE;
            r_div   <= '0;
            r_bcnt  <= '0;
            r_shreg <= '0;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
          if (w_acc_vld) begin
            r_shreg <= {r_shreg[BYTE_W-2:0], w_acc_bit};
            if (r_bcnt == BIT_LAST) begin
              r_state      <= ST_HOLD;
              r_data_out   <= {r_shreg[BYTE_W-2:0], w_acc_bit};
              r_data_valid <= 1'b1;
              r_bcnt       <= '0;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (data_ready) begin
            r_state      <= ST_SAMPLE;
            r_data_valid <= 1'b0;
            r_div        <= '0;
            r_bcnt       <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ro_en      = r_ro_en;
  assign busy       = r_busy;
  assign data_valid = r_data_valid;
  assign data_out   = r_data_out;
endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: directed sample sequences, scoreboard of expected bytes popped on handshake.
module tb_trng_ctrl;
  localparam int N_RO = 4;
  localparam int WARMUP_CYCLES = 64;
  localparam int SAMPLE_DIV = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            ro_en;
  logic [N_RO-1:0] ro_bits = '0;
  logic [7:0]      data_out;
  logic            data_valid;
  logic            data_ready = 1'b0;
  logic            busy;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  trng_ctrl #(
    .N_RO(N_RO), .WARMUP_CYCLES(WARMUP_CYCLES), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ro_en(ro_en), .ro_bits(ro_bits),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Several oscillator patterns per XOR value so the reduction itself is exercised.
  function automatic logic [N_RO-1:0] pat(input logic b, input int i);
    logic [N_RO-1:0] p;
    case (i % 3)
      0:       p = b ? 4'b0001 : 4'b0000;
      1:       p = b ? 4'b1110 : 4'b0011;
      default: p = b ? 4'b0100 : 4'b1111;
    endcase
    return p;
  endfunction

  // Called 1ns after an edge; first sample edge is `lead` edges later, then every SAMPLE_DIV.
  task automatic drive_raw(input logic [31:0] v, input int n, input int lead);
    for (int i = 0; i < n; i++) begin
      ro_bits = pat(v[n-1-i], i);
      repeat (((i == 0) ? lead : SAMPLE_DIV) - 1) @(posedge clk);
      #1;
      if (i == n - 1) chk("vld_low_before_last_sample", 32'(data_valid), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic handshake();
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    data_ready = 1'b0;
    chk("vld_drop_after_handshake", 32'(data_valid), 32'd0);
  endtask

  task automatic enable_run();
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("ro_en_after_enable", 32'(ro_en), 32'd1);
    chk("busy_after_enable", 32'(busy), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("byte", 32'(data_out), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    #12;
    chk("rst_ro_en", 32'(ro_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(data_valid), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_ro_en", 32'(ro_en), 32'd0);

`ifndef TRNG_VON_NEUMANN_EN
    enable_run();
    exp_q.push_back(8'hB2);
    drive_raw(32'hB2, 8, WARMUP_CYCLES + SAMPLE_DIV);
    chk("vld_after_byte_b2", 32'(data_valid), 32'd1);
    hi = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (data_valid) hi++;
    end
    chk("hold_20_cycles", 32'(hi), 32'd20);
    chk("hold_dout", 32'(data_out), 32'hB2);
    handshake();

    exp_q.push_back(8'hFF);
    drive_raw(32'hFF, 8, SAMPLE_DIV);
    chk("vld_after_byte_ff", 32'(data_valid), 32'd1);
    handshake();
    exp_q.push_back(8'h00);
    drive_raw(32'h00, 8, SAMPLE_DIV);
    chk("vld_after_byte_00", 32'(data_valid), 32'd1);
    handshake();

    // Abort mid-byte after 5 bits.
    drive_raw(32'h16, 5, SAMPLE_DIV);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ro_en", 32'(ro_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_vld", 32'(data_valid), 32'd0);

    enable_run();
    exp_q.push_back(8'h5A);
    drive_raw(32'h5A, 8, WARMUP_CYCLES + SAMPLE_DIV);
    chk("vld_after_byte_5a", 32'(data_valid), 32'd1);
    handshake();

    // Abort while holding an unaccepted byte.
    drive_raw(32'hC3, 8, SAMPLE_DIV);
    chk("vld_after_byte_c3", 32'(data_valid), 32'd1);
    chk("dout_c3", 32'(data_out), 32'hC3);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_abort_vld", 32'(data_valid), 32'd0);
    chk("hold_abort_ro_en", 32'(ro_en), 32'd0);
    chk("hold_abort_busy", 32'(busy), 32'd0);

    enable_run();
    exp_q.push_back(8'h3C);
    drive_raw(32'h3C, 8, WARMUP_CYCLES + SAMPLE_DIV);
    chk("vld_after_byte_3c", 32'(data_valid), 32'd1);
    handshake();
`else
    enable_run();
    exp_q.push_back(8'h6C);
    drive_raw(32'b0111100010, 10, WARMUP_CYCLES + SAMPLE_DIV);
    chk("vn_no_vld_after_3_bits", 32'(data_valid), 32'd0);
    drive_raw(32'b0110100101, 10, SAMPLE_DIV);
    chk("vn_vld_after_8_bits", 32'(data_valid), 32'd1);
    chk("vn_dout", 32'(data_out), 32'h6C);
    handshake();
`endif

    // Reset in the middle of SAMPLE.
    repeat (20) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ro_en", 32'(ro_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_vld", 32'(data_valid), 32'd0);
    chk("midrst_dout", 32'(data_out), 32'd0);
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_ro_en", 32'(ro_en), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/trng_ctrl.md
# trng_ctrl

Sequencing controller for the ring-oscillator entropy source. Enables a bank of free-running ring oscillators, waits out a warm-up period, and synchronises and XOR-combines their outputs. Samples the combined bit at a fixed divided rate, optionally debiases it, and packs the bits into bytes delivered over a valid/ready handshake. It sits between the ring-oscillator instances and the design's user I/O or register logic.

## Interface
- `N_RO`, 4: number of ring oscillators driven and sampled (1..8).
- `WARMUP_CYCLES`, 64: clk cycles spent in WARMUP after enabling oscillators (≥1).
- `SAMPLE_DIV`, 8: clk cycles between raw samples (≥2).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run request; level-sensitive.
- `ro_en`  out  1  enable to every ring oscillator (one shared net).
- `ro_bits`  in  N_RO  oscillator outputs; asynchronous to `clk`.
- `data_out`  out  8  assembled random byte.
- `data_valid`  out  1  `data_out` holds a complete byte.
- `data_ready`  in  1  consumer accepts byte when high with `data_valid`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WARMUP, SAMPLE, HOLD.
- IDLE: `ro_en`=0. `en`=1 → WARMUP, warm-up counter cleared.
- WARMUP: `ro_en`=1. After `WARMUP_CYCLES` cycles → SAMPLE, with the divider and bit counter cleared.
- SAMPLE: `ro_en`=1. Divider counts 0..SAMPLE_DIV-1; at terminal count a raw bit = XOR of all synchronised `ro_bits`. Accepted bits shift into the shift register LSB-first-in (shift left, new bit at bit 0). On the 8th accepted bit → HOLD; `data_out` is loaded from the shift register.
- HOLD: `ro_en`=1 (oscillators keep running), `data_valid`=1, divider frozen. On `data_valid && data_ready` → SAMPLE, with the bit counter and divider cleared.
- `en`=0 in any non-IDLE state → IDLE next cycle. The partial byte is discarded and `data_valid` is cleared even if unaccepted; this is the only case where valid drops without a handshake.
- `en`=1 with handshake in the same HOLD cycle: the handshake completes and the FSM goes to SAMPLE.
- Synchroniser: each `ro_bits[i]` passes through 2 flops, reset to 0. It runs regardless of state.
- Counters are sized with `$clog2` of their limits; no wrap beyond the terminal count.

## Timing
- Reset values: `ro_en`=0, `data_out`=8'h00, `data_valid`=0, `busy`=0. The state is IDLE and all counters and synchronisers are 0.
- `ro_en` and `busy` are registered. `en` sampled high at edge k gives `ro_en`=1 after edge k.
- The first raw sample is taken `WARMUP_CYCLES + SAMPLE_DIV` cycles after entering WARMUP.
- Raw bit reflects `ro_bits` as it was 2 cycles earlier, due to the synchroniser.
- Without debiasing, a byte takes 8·SAMPLE_DIV cycles in SAMPLE. `data_valid` rises the cycle after the 8th sample edge.
- After a handshake, the next sample occurs SAMPLE_DIV cycles after entering SAMPLE.
- Reset mid-operation returns immediately to the reset values; the byte in flight is lost.

## Configuration
- `TRNG_VON_NEUMANN_EN` defined: raw samples are paired (first, second).
  - 01 → accept 0; 10 → accept 1; 00/11 → discard the pair.
  - The pair register clears on entry to SAMPLE and on `en`=0.
  - Byte time is variable, minimum 16·SAMPLE_DIV cycles.
- Undefined: every raw sample is accepted directly; byte time is fixed at 8·SAMPLE_DIV.

## Structure
- Package `trng_pkg`: the state enum (IDLE, WARMUP, SAMPLE, HOLD), the byte-width constant 8, and default parameter constants.
- One sub-module: `trng_sync`, an N_RO-wide 2-flop synchroniser with async active-low reset, instantiated once.
- The ring-oscillator instances live outside this block. The bench drives `ro_bits` directly, because the oscillators do not simulate.

## Test plan
- Reset: assert `rst_n`=0 mid-SAMPLE → all outputs at reset values. With `en`=0 after release, the block stays IDLE and `ro_en` stays 0.
- Warm-up: WARMUP_CYCLES=64, SAMPLE_DIV=8, `en`=1 → `ro_en`=1 one cycle later, and no sample before cycle 72 after WARMUP entry.
- Raw byte (macro off): N_RO=4, force the XOR sequence 1,0,1,1,0,0,1,0 at each sample point → `data_out`=8'hB2, `data_valid`=1, which holds for 20 cycles with `data_ready`=0.
- Handshake: `data_ready`=1 in HOLD → `data_valid`=0 next cycle, and the next byte is assembled. Back-to-back bytes 8'hFF then 8'h00 come out correctly.
- Abort: `en`=0 after 5 bits, and separately in HOLD with `data_valid`=1 → IDLE next cycle, `ro_en`=0, `data_valid`=0. Re-enabling gives a fresh warm-up and no stale bits.
- Debias (macro on): pairs 01,11,10,00,10 … → accepted bits 0,1,1 only; `data_valid` rises only after 8 accepted bits.
